// File: rtl/bus_rr_pkg.sv
// Shared types and arbitration/decode helpers for the multi-lane bus router.
// The helpers work on MAX_DRVRS-wide vectors so that one package serves every lane width.
package bus_rr_pkg;

  localparam int unsigned MAX_DRVRS = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned MAX_ID_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    ROUTE,
    PUSH
  } lane_state_e;

  typedef struct packed {
    logic [MAX_DRVRS-1:0] mask;
    logic                 invalid;
  } dest_t;

  // First requester at or after ptr, wrapping modulo n; a zero ptr gives lowest-index priority.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_DRVRS-1:0] pndng,
    input logic [IDX_W-1:0]     ptr,
    input int unsigned          n
  );
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] k;
    logic             found;
    int unsigned      idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_DRVRS; i++) begin
      idx = (32'(ptr) + i) % n;
      k   = IDX_W'(idx);
      if (!found && (i < n) && pndng[k]) begin
        g     = k;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Target set for a destination ID: broadcast skips the source, IDs beyond n are invalid.
  function automatic dest_t dest_mask(
    input logic [MAX_ID_W-1:0] id,
    input logic [MAX_ID_W-1:0] bcast,
    input logic [IDX_W-1:0]    src,
    input int unsigned         n
  );
    dest_t d;
    d.mask    = '0;
    d.invalid = 1'b0;
    if (id == bcast) begin
      for (int unsigned i = 0; i < MAX_DRVRS; i++) begin
        d.mask[i] = (i < n) && (i != 32'(src));
      end
    end else if (id < MAX_ID_W'(n)) begin
      d.mask[IDX_W'(id)] = 1'b1;
    end else begin
      d.invalid = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bus_rr_lane.sv
// One bus lane: arbitrates among its drivers, pops one packet, then pushes it to
// one destination, all-but-source on broadcast, or drops it with an error pulse.
module bus_rr_lane
  import bus_rr_pkg::*;
#(
  parameter int unsigned     drvrs     = 4,
  parameter int unsigned     pckg_size = 32,
  parameter int unsigned     id_w      = 8,
  parameter logic [id_w-1:0] broadcast = {id_w{1'b1}}
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_size-1:0] d_pop,
  input  logic [drvrs-1:0]                full,
  input  logic                            arb_mode,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_size-1:0]            d_push,
  output logic                            err_dest,
  output logic                            busy
);

  lane_state_e          state_q, state_d;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     grant_d;
  logic [pckg_size-1:0] pkt_q;
  logic [pckg_size-1:0] dpush_q;
  logic [pckg_size-1:0] head;
  logic [id_w-1:0]      id;
  dest_t                dest;
  logic                 blocked;

  assign grant_d = rr_pick(MAX_DRVRS'(pndng), arb_mode ? IDX_W'(0) : ptr_q, drvrs);

  assign id      = pkt_q[pckg_size-1 -: id_w];
  assign dest    = dest_mask(MAX_ID_W'(id), MAX_ID_W'(broadcast), grant_q, drvrs);
  assign blocked = |(dest.mask & MAX_DRVRS'(full));

  always_comb begin
    head = '0;
    for (int i = 0; i < int'(drvrs); i++) begin
      if (grant_q == IDX_W'(i)) head = d_pop[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pndng) state_d = POP;
      POP:     state_d = ROUTE;
      // The whole target set must be ready at once: broadcasts are never split.
      ROUTE: begin
        if (dest.invalid)  state_d = IDLE;
        else if (!blocked) state_d = PUSH;
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dpush_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == POP) ptr_q <= IDX_W'((32'(grant_q) + 32'd1) % drvrs);
      if ((state_q == ROUTE) && (state_d == PUSH)) dpush_q <= pkt_q;
    end
  end

  // Data capture: only consumed in states that reset already steers away from.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) grant_q <= grant_d;
    if (state_q == POP)  pkt_q   <= head;
  end

  always_comb begin
    pop  = '0;
    push = '0;
    for (int i = 0; i < int'(drvrs); i++) begin
      pop[i] = (state_q == POP) && (grant_q == IDX_W'(i));
    end
    if (state_q == PUSH) push = drvrs'(dest.mask);
  end

  assign err_dest = (state_q == ROUTE) && dest.invalid;
  assign busy     = (state_q != IDLE);
  assign d_push   = dpush_q;

endmodule

// File: rtl/bus_rr_router.sv
// Multi-lane bus router: `bits` independent lanes, each with its own arbiter and
// packet register; the lane's packet is fanned out identically to all its drivers.
module bus_rr_router
  import bus_rr_pkg::*;
#(
  parameter int unsigned     bits      = 1,
  parameter int unsigned     drvrs     = 4,
  parameter int unsigned     pckg_size = 32,
  parameter int unsigned     id_w      = 8,
  parameter logic [id_w-1:0] broadcast = {id_w{1'b1}}
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [bits-1:0][drvrs-1:0]                 pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_size-1:0]  D_pop,
  input  logic [bits-1:0][drvrs-1:0]                 full,
  input  logic                                       arb_mode,
  output logic [bits-1:0][drvrs-1:0]                 pop,
  output logic [bits-1:0][drvrs-1:0]                 push,
  output logic [bits-1:0][drvrs-1:0][pckg_size-1:0]  D_push,
  output logic [bits-1:0]                            err_dest,
  output logic [bits-1:0]                            busy
);

  for (genvar l = 0; l < int'(bits); l++) begin : g_lane
    logic [pckg_size-1:0] lane_pkt;

    bus_rr_lane #(
      .drvrs     (drvrs),
      .pckg_size (pckg_size),
      .id_w      (id_w),
      .broadcast (broadcast)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .pndng    (pndng[l]),
      .d_pop    (D_pop[l]),
      .full     (full[l]),
      .arb_mode (arb_mode),
      .pop      (pop[l]),
      .push     (push[l]),
      .d_push   (lane_pkt),
      .err_dest (err_dest[l]),
      .busy     (busy[l])
    );

    for (genvar d = 0; d < int'(drvrs); d++) begin : g_drv
      assign D_push[l][d] = lane_pkt;
    end
  end

endmodule

// File: tb/tb_bus_rr_router.sv
// Self-checking bench for bus_rr_router: directed vector table, corner sequences,
// and randomized traffic against a transaction-timeline reference model.
module tb_bus_rr_router;

  localparam int NL = 2;
  localparam int ND = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NL-1:0][ND-1:0]       pndng;
  logic [NL-1:0][ND-1:0][31:0] D_pop;
  logic [NL-1:0][ND-1:0]       full;
  logic                        arb_mode;
  logic [NL-1:0][ND-1:0]       pop;
  logic [NL-1:0][ND-1:0]       push;
  logic [NL-1:0][ND-1:0][31:0] D_push;
  logic [NL-1:0]               err_dest;
  logic [NL-1:0]               busy;

  bus_rr_router #(.bits(NL), .drvrs(ND), .pckg_size(32), .id_w(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .full     (full),
    .arb_mode (arb_mode),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .err_dest (err_dest),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    next_cycle();
    reset = 1'b1;
    pndng = '0;
    full  = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    int          drv;
    logic [31:0] pkt;
    logic [3:0]  exp_push;
    logic        exp_err;
    logic [31:0] exp_dpush;
  } vec_t;

  vec_t tbl[7];

  // One isolated transfer on lane 0, full idle; fixed 1/2/3 cycle timeline.
  task automatic run_vec(input vec_t v, input int idx);
    next_cycle();
    pndng[0]        = 4'(1 << v.drv);
    D_pop[0][v.drv] = v.pkt;
    next_cycle();
    @(negedge clk);
    chk($sformatf("tbl%0d_pop", idx), 32'(pop[0]), 32'(1 << v.drv));
    next_cycle();
    pndng[0] = '0;
    @(negedge clk);
    chk($sformatf("tbl%0d_err", idx), 32'(err_dest[0]), 32'(v.exp_err));
    next_cycle();
    @(negedge clk);
    chk($sformatf("tbl%0d_push", idx), 32'(push[0]), 32'(v.exp_push));
    chk($sformatf("tbl%0d_dpush", idx), D_push[0][0], v.exp_dpush);
    next_cycle();
    @(negedge clk);
    chk($sformatf("tbl%0d_idle", idx), 32'(busy[0]), 32'd0);
  endtask

  // Reference model state (per lane, transaction timeline in cycle numbers).
  int          m_ptr[NL], m_g[NL], m_t0[NL], m_done[NL];
  bit          m_act[NL], m_inv[NL];
  logic [31:0] m_pkt[NL], m_last[NL];
  logic [3:0]  m_mask[NL];
  logic [31:0] dq[NL][ND][$];

  function automatic int model_pick(input logic [3:0] req, input int ptr, input logic mode);
    int start;
    start = mode ? 0 : ptr;
    for (int k = 0; k < ND; k++) begin
      if (req[(start + k) % ND]) return (start + k) % ND;
    end
    return 0;
  endfunction

  initial begin
    int          got;
    logic        seen;
    logic [31:0] r;
    logic [NL-1:0][ND-1:0] pop_s;
    logic [3:0]  e_pop, e_push;
    logic        e_err, e_busy;
    logic [31:0] e_dpush;
    int          id;

    tbl[0] = '{1, 32'h0200ABCD, 4'b0100, 1'b0, 32'h0200ABCD};
    tbl[1] = '{0, 32'hFF001234, 4'b1110, 1'b0, 32'hFF001234};
    tbl[2] = '{2, 32'h07000000, 4'b0000, 1'b1, 32'hFF001234};
    tbl[3] = '{3, 32'h03000055, 4'b1000, 1'b0, 32'h03000055};
    tbl[4] = '{0, 32'h04000099, 4'b0000, 1'b1, 32'h03000055};
    tbl[5] = '{3, 32'hFFABCDEF, 4'b0111, 1'b0, 32'hFFABCDEF};
    tbl[6] = '{2, 32'h00000001, 4'b0001, 1'b0, 32'h00000001};

    reset    = 1'b1;
    pndng    = '0;
    D_pop    = '0;
    full     = '0;
    arb_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pop",   32'(pop), 32'd0);
    chk("rst_push",  32'(push), 32'd0);
    chk("rst_err",   32'(err_dest), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_dpush", 32'(|D_push), 32'd0);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Round-robin then fixed-priority grant order with all drivers requesting.
    reset_dut();
    for (int d = 0; d < ND; d++) D_pop[0][d] = {8'(d), 24'h000100};
    pndng[0] = 4'hF;
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      if (pop[0] != 0) begin
        chk($sformatf("rr_grant%0d", got), 32'(pop[0]), 32'(1 << (got % ND)));
        got++;
      end
    end
    chk("rr_count", got, 8);
    arb_mode = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (pop[0] != 0) begin
        chk($sformatf("fp_grant%0d", got), 32'(pop[0]), 32'h1);
        got++;
      end
    end
    chk("fp_count", got, 4);
    pndng[0] = '0;
    arb_mode = 1'b0;
    repeat (6) next_cycle();

    // Backpressure: destination 3 full for 10 ROUTE cycles.
    reset_dut();
    full[0]     = 4'b1000;
    D_pop[0][0] = 32'h0300BEEF;
    pndng[0]    = 4'b0001;
    next_cycle();
    next_cycle();
    pndng[0] = '0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!busy[0] || push[0] != 0) seen = 1'b1;
      next_cycle();
    end
    chk("bp_held", 32'(seen), 32'd0);
    full[0] = '0;
    @(negedge clk);
    chk("bp_no_early_push", 32'(push[0]), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("bp_push", 32'(push[0]), 32'h8);
    chk("bp_dpush", D_push[0][3], 32'h0300BEEF);
    next_cycle();
    @(negedge clk);
    chk("bp_idle", 32'(busy[0]), 32'd0);

    // Reset while stalled in ROUTE aborts the transfer.
    full[0]     = 4'b0100;
    D_pop[0][1] = 32'h02000777;
    pndng[0]    = 4'b0010;
    next_cycle();
    next_cycle();
    pndng[0] = '0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset   = 1'b0;
    full[0] = '0;
    @(negedge clk);
    chk("rr_rst_outs", 32'({pop[0], push[0], err_dest[0], busy[0]}), 32'd0);
    chk("rr_rst_dpush", D_push[0][0], 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clk);
      if (push[0] != 0 || busy[0]) seen = 1'b1;
    end
    chk("rr_rst_no_push", 32'(seen), 32'd0);

    // Two lanes in lock-step.
    D_pop[0][1] = 32'h02000111;
    D_pop[1][2] = 32'h00000222;
    pndng[0]    = 4'b0010;
    pndng[1]    = 4'b0100;
    next_cycle();
    @(negedge clk);
    chk("ml_pop", 32'({pop[1], pop[0]}), 32'h42);
    next_cycle();
    pndng = '0;
    next_cycle();
    @(negedge clk);
    chk("ml_push", 32'({push[1], push[0]}), 32'h14);
    chk("ml_dpush0", D_push[0][2], 32'h02000111);
    seen = 1'b0;
    for (int d = 0; d < ND; d++) if (D_push[1][d] !== 32'h00000222) seen = 1'b1;
    chk("ml_dpush1_fanout", 32'(seen), 32'd0);
    next_cycle();

    // Randomized traffic on both lanes against the reference model.
    reset_dut();
    for (int l = 0; l < NL; l++) begin
      m_act[l]  = 1'b0;
      m_ptr[l]  = 0;
      m_last[l] = '0;
    end
    pop_s = '0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if ($urandom_range(0, 39) == 0) arb_mode = ~arb_mode;
      for (int l = 0; l < NL; l++) begin
        for (int d = 0; d < ND; d++) begin
          if (pop_s[l][d] && dq[l][d].size() > 0) void'(dq[l][d].pop_front());
          if (dq[l][d].size() < 4 && $urandom_range(0, 5) == 0) begin
            r = $urandom();
            case ($urandom_range(0, 9))
              0, 1, 2, 3, 4, 5: r[31:24] = 8'($urandom_range(0, ND - 1));
              6, 7:             r[31:24] = 8'hFF;
              default:          r[31:24] = 8'($urandom_range(ND, 254));
            endcase
            dq[l][d].push_back(r);
          end
          pndng[l][d] = (dq[l][d].size() != 0);
          D_pop[l][d] = (dq[l][d].size() != 0) ? dq[l][d][0] : $urandom();
          full[l][d]  = ($urandom_range(0, 3) == 0);
        end
      end
      @(negedge clk);
      pop_s = pop;
      for (int l = 0; l < NL; l++) begin
        e_pop   = (m_act[l] && c == m_t0[l]) ? 4'(1 << m_g[l]) : 4'b0;
        e_err   = m_act[l] && m_inv[l] && c == m_done[l];
        e_push  = (m_act[l] && !m_inv[l] && c == m_done[l]) ? m_mask[l] : 4'b0;
        e_dpush = (m_act[l] && !m_inv[l] && c == m_done[l]) ? m_pkt[l] : m_last[l];
        e_busy  = m_act[l] && c >= m_t0[l];
        chk($sformatf("rnd_pop_l%0d_c%0d", l, c),   32'(pop[l]), 32'(e_pop));
        chk($sformatf("rnd_push_l%0d_c%0d", l, c),  32'(push[l]), 32'(e_push));
        chk($sformatf("rnd_err_l%0d_c%0d", l, c),   32'(err_dest[l]), 32'(e_err));
        chk($sformatf("rnd_busy_l%0d_c%0d", l, c),  32'(busy[l]), 32'(e_busy));
        chk($sformatf("rnd_dpush_l%0d_c%0d", l, c), D_push[l][c % ND], e_dpush);

        if (m_act[l]) begin
          if (c == m_t0[l]) begin
            m_pkt[l] = dq[l][m_g[l]][0];
            id = int'(m_pkt[l][31:24]);
            m_inv[l]  = 1'b0;
            m_mask[l] = '0;
            if (id == 255)    m_mask[l] = 4'hF & ~4'(1 << m_g[l]);
            else if (id < ND) m_mask[l] = 4'(1 << id);
            else              m_inv[l] = 1'b1;
            m_done[l] = m_inv[l] ? c + 1 : -1;
          end else if (m_done[l] < 0) begin
            if ((m_mask[l] & full[l]) == 4'b0) m_done[l] = c + 1;
          end else if (c == m_done[l]) begin
            m_act[l] = 1'b0;
            if (!m_inv[l]) m_last[l] = m_pkt[l];
          end
        end else if (pndng[l] != 0) begin
          m_g[l]    = model_pick(pndng[l], m_ptr[l], arb_mode);
          m_ptr[l]  = (m_g[l] + 1) % ND;
          m_act[l]  = 1'b1;
          m_t0[l]   = c + 1;
          m_done[l] = -1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
